// File: rtl/div_pkg.sv
// Shared FSM states, divide-by-zero quotient constant and counter sizing
// for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sliced down to the operand width at the point of use.
  localparam logic [63:0] DZ_QUOT = '1;

  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sub_cla.sv
// Combinational N-bit subtractor a - b, built as a parallel-prefix
// lookahead adder on a + ~b + 1; borrow is the inverted carry-out.
module sub_cla #(
  parameter int N = 9
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_diff,
  output logic         o_borrow
);

  logic [N-1:0] w_g;
  logic [N-1:0] w_p;
  logic [N-1:0] w_gc;
  logic [N-1:0] w_pc;
  logic [N-1:0] w_gn;
  logic [N-1:0] w_pn;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_gp
      assign w_g[gi] = i_a[gi] & ~i_b[gi];
      assign w_p[gi] = i_a[gi] ^ ~i_b[gi];
    end
  endgenerate

  // Kogge-Stone prefix; the constant carry-in of 1 is folded into bit 0.
  always_comb begin
    w_gc    = w_g;
    w_pc    = w_p;
    w_gc[0] = w_g[0] | w_p[0];
    w_gn    = w_gc;
    w_pn    = w_pc;
    for (int d = 1; d < N; d = d * 2) begin
      w_gn = w_gc;
      w_pn = w_pc;
      for (int i = d; i < N; i++) begin
        w_gn[i] = w_gc[i] | (w_pc[i] & w_gc[i-d]);
        w_pn[i] = w_pc[i] & w_pc[i-d];
      end
      w_gc = w_gn;
      w_pc = w_pn;
    end
  end

  assign o_diff   = {w_p[N-1:1] ^ w_gc[N-2:0], ~w_p[0]};
  assign o_borrow = ~w_gc[N-1];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, valid/ready on
// both sides. Define SEQ_DIV_SIGNED_EN for two's complement operands.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  import div_pkg::*;

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH:0]   r_prem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_dz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_sub_a;
  logic [WIDTH:0]   w_sub_b;
  logic [WIDTH:0]   w_sub_diff;
  logic             w_borrow;
  logic [WIDTH:0]   w_prem_next;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_rem_fin;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic             w_unused_prem_msb;

  sub_cla #(.N(WIDTH + 1)) u_sub (
    .i_a      (w_sub_a),
    .i_b      (w_sub_b),
    .o_diff   (w_sub_diff),
    .o_borrow (w_borrow)
  );

  assign w_shift     = {r_prem[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_prem_next = w_borrow ? w_shift : w_sub_diff;
  assign w_q_next    = {r_q[WIDTH-2:0], ~w_borrow};
  // The partial remainder never reaches the divisor, so its top bit is always 0.
  assign w_unused_prem_msb = r_prem[WIDTH];

`ifdef SEQ_DIV_SIGNED_EN
  logic r_sa;
  logic r_sb;

  // The subtractor is idle in IDLE, so it forms the dividend magnitude there.
  always_comb begin
    if (r_state == IDLE) begin
      w_sub_a = '0;
      w_sub_b = {1'b0, dividend};
    end else begin
      w_sub_a = w_shift;
      w_sub_b = {1'b0, r_div};
    end
  end

  assign w_dvd_mag = dividend[WIDTH-1] ? w_sub_diff[WIDTH-1:0] : dividend;
  assign w_dvs_mag = divisor[WIDTH-1] ? ((~divisor) + WIDTH'(1)) : divisor;
  assign w_q_fin   = (r_sa ^ r_sb) ? ((~w_q_next) + WIDTH'(1)) : w_q_next;
  assign w_rem_fin = r_sa ? ((~w_prem_next[WIDTH-1:0]) + WIDTH'(1))
                          : w_prem_next[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa <= 1'b0;
      r_sb <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_sa <= dividend[WIDTH-1];
      r_sb <= divisor[WIDTH-1];
    end
  end
`else
  assign w_sub_a   = w_shift;
  assign w_sub_b   = {1'b0, r_div};
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
  assign w_q_fin   = w_q_next;
  assign w_rem_fin = w_prem_next[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = (divisor == '0) ? DONE : CALC;
      CALC:    if (r_cnt == '0) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prem <= '0;
      r_q    <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_dz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              r_q    <= DZ_QUOT[WIDTH-1:0];
              r_prem <= {1'b0, dividend};
              r_dz   <= 1'b1;
            end else begin
              r_prem <= '0;
              r_q    <= w_dvd_mag;
              r_div  <= w_dvs_mag;
              r_cnt  <= CNT_LAST;
              r_dz   <= 1'b0;
            end
          end
        end
        CALC: begin
          if (r_cnt == '0) begin
            r_q    <= w_q_fin;
            r_prem <= {1'b0, w_rem_fin};
          end else begin
            r_q    <= w_q_next;
            r_prem <= w_prem_next;
            r_cnt  <= r_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_q;
  assign remainder   = r_prem[WIDTH-1:0];
  assign div_by_zero = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: latency, results, backpressure,
// divide-by-zero and mid-calculation reset.
module tb_seq_divider;
  localparam int W = 8;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] dividend  = '0;
  logic [W-1:0] divisor   = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Called #1 after a rising edge with the divider idle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                        input logic exp_dz, input int exp_lat, input int hold);
    int   lat;
    logic busy_bad;
    logic hold_bad;
    busy_bad = 1'b0;
    hold_bad = 1'b0;
    chk("ready_before_op", 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    // Keep in_valid high with scrambled operands: the busy divider must ignore them.
    dividend = ~a;
    divisor  = b + 8'd3;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("ready_low_busy", 32'(busy_bad), 32'd0);
    chk("ready_low_done", 32'(in_ready), 32'd0);
    chk("quotient", 32'(quotient), 32'(exp_q));
    chk("remainder", 32'(remainder), 32'(exp_r));
    chk("div_by_zero", 32'(div_by_zero), 32'(exp_dz));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (!out_valid || in_ready || quotient !== exp_q ||
            remainder !== exp_r || div_by_zero !== exp_dz) hold_bad = 1'b1;
      end
      chk("hold_stable", 32'(hold_bad), 32'd0);
    end
    out_ready = 1'b1;
    chk("ready_low_at_release", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("valid_dropped", 32'(out_valid), 32'd0);
    chk("ready_after_release", 32'(in_ready), 32'd1);
    $display("op 0x%0h / 0x%0h -> q=0x%0h r=0x%0h dz=%0d lat=%0d hold=%0d",
             a, b, quotient, remainder, div_by_zero, lat, hold);
  endtask

  initial begin
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 9, 0);
    run_op(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 9, 0);
    run_op(8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 9, 0);
    run_op(8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 9, 0);
    run_op(8'd77,  8'd0,   8'd255, 8'd77, 1'b1, 1, 0);
`ifdef SEQ_DIV_SIGNED_EN
    run_op(8'd200, 8'd3,   8'hEE,  8'hFE, 1'b0, 9, 6);
    run_op(8'h9C,  8'd7,   8'hF2,  8'hFE, 1'b0, 9, 0);
    run_op(8'h80,  8'hFF,  8'h80,  8'h00, 1'b0, 9, 0);
`else
    run_op(8'd200, 8'd3,   8'd66,  8'd2,  1'b0, 9, 6);
    run_op(8'd200, 8'd13,  8'd15,  8'd5,  1'b0, 9, 0);
`endif

    // Abort during the 4th calculation cycle.
    dividend = 8'd100;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_dz", 32'(div_by_zero), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_abort_ready", 32'(in_ready), 32'd1);
    chk("post_abort_valid", 32'(out_valid), 32'd0);
    run_op(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 9, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
